// File: rtl/rx.sv
// UART-style serial receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop bit.
// A completed frame is held on Dout/parityErr/frameErr with Receive high until ReceiveAck.
module rx #(
   parameter int CLK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE     = 19_200,
   parameter int PARITY        = 1
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       Sin,
   input  logic       ReceiveAck,
   output logic       Receive,
   output logic [7:0] Dout,
   output logic       parityErr,
   output logic       frameErr
);

   localparam int BIT_CYCLES  = CLK_FREQUENCY / BAUD_RATE;
   localparam int HALF_CYCLES = BIT_CYCLES / 2;
   localparam int TIMER_W     = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [TIMER_W-1:0] BIT_LAST  = TIMER_W'(BIT_CYCLES - 1);
   localparam logic [TIMER_W-1:0] HALF_LAST = TIMER_W'(HALF_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY_BIT,
      STOP,
      ACK
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [TIMER_W-1:0] timer;
   logic [2:0]         bit_cnt;
   logic [7:0]         shift_reg;
   logic               parity_bit;
   logic               sin_meta;
   logic               sin_sync;
   logic               bit_done;
   logic               parity_sum;
   logic               parity_bad;

   assign bit_done   = (timer == BIT_LAST);
   assign parity_sum = (^shift_reg) ^ parity_bit;
   // Odd parity expects the nine bits to XOR to 1, even parity to 0.
   assign parity_bad = (PARITY != 0) ? ~parity_sum : parity_sum;

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         sin_meta <= 1'b1;
         sin_sync <= 1'b1;
      end else begin
         sin_meta <= Sin;
         sin_sync <= sin_meta;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (!sin_sync) state_next = START;
         end
         START: begin
            // Re-check the line at mid start bit so short glitches are rejected.
            if (timer == HALF_LAST) state_next = sin_sync ? IDLE : DATA;
         end
         DATA: begin
            if (bit_done && bit_cnt == 3'd7) state_next = PARITY_BIT;
         end
         PARITY_BIT: begin
            if (bit_done) state_next = STOP;
         end
         STOP: begin
            if (bit_done) state_next = ACK;
         end
         ACK: begin
            if (ReceiveAck) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Timer restarts on every state change and on each full bit period while sampling.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         timer <= '0;
      end else if (state_next != state || bit_done || state == IDLE || state == ACK) begin
         timer <= '0;
      end else begin
         timer <= timer + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'h00;
         parity_bit <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bit_cnt <= 3'd0;
            end
            DATA: begin
               if (bit_done) begin
                  shift_reg <= {sin_sync, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
               end
            end
            PARITY_BIT: begin
               if (bit_done) parity_bit <= sin_sync;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         Receive   <= 1'b0;
         Dout      <= 8'h00;
         parityErr <= 1'b0;
         frameErr  <= 1'b0;
      end else begin
         Receive <= (state_next == ACK);
         if (state == STOP && bit_done) begin
            Dout      <= shift_reg;
            parityErr <= parity_bad;
            frameErr  <= ~sin_sync;
         end
      end
   end

endmodule
